pulse_rate_gen: RTL

PULSE_RATE_GEN -- requirements
Module: pulse_rate_gen

---
 rtl/pulse_rate_pkg.sv | 13 +
 rtl/rate_down_counter.sv | 33 +++
 rtl/pulse_rate_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pulse_rate_pkg.sv
// Shared definitions for the programmable tick generator: FSM state encodings
// and the default period width.
package pulse_rate_pkg;

    localparam int DEFAULT_WIDTH = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/rate_down_counter.sv
// Loadable down-counter with clear, count enable and a zero flag.
// Priority is reset > clear > load > enable.
module rate_down_counter
    import pulse_rate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pulse_rate_gen.sv
// Programmable periodic tick generator with pause, stop and one-shot modes;
// counts issued ticks since the last start.
module pulse_rate_gen
    import pulse_rate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             one_shot,
    input  logic             period_load,
    input  logic [WIDTH-1:0] period_in,
    output logic             tick,
    output logic [1:0]       state,
    output logic [7:0]       tick_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_active, w_active_nxt;
    logic [WIDTH-1:0] r_pending, w_pend_nxt;
    logic             r_one_shot, w_one_shot_nxt;
    logic             r_tick, w_tick_nxt;
    logic [7:0]       r_tick_count, w_tick_count_nxt;
    logic             w_cnt_clr, w_cnt_load, w_cnt_en, w_cnt_zero;
    logic [WIDTH-1:0] w_load_val;

    // A period of 0 behaves like 1, so both reload the counter with 0.
    function automatic logic [WIDTH-1:0] reload_value(input logic [WIDTH-1:0] p);
        return (p == '0) ? '0 : p - ONE;
    endfunction

    always_comb begin
        w_pend_nxt       = period_load ? period_in : r_pending;
        w_load_val       = reload_value(w_pend_nxt);
        w_state_nxt      = r_state;
        w_active_nxt     = r_active;
        w_one_shot_nxt   = r_one_shot;
        w_tick_nxt       = 1'b0;
        w_tick_count_nxt = r_tick_count;
        w_cnt_clr        = 1'b0;
        w_cnt_load       = 1'b0;
        w_cnt_en         = 1'b0;

        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_clr   = 1'b1;
        end else if (start) begin
            w_state_nxt      = ST_RUN;
            w_active_nxt     = w_pend_nxt;
            w_cnt_load       = 1'b1;
            w_tick_count_nxt = 8'd0;
            w_one_shot_nxt   = one_shot;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_active_nxt = w_pend_nxt;
                    w_cnt_clr    = 1'b1;
                end
                ST_RUN, ST_PAUSE: begin
                    if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else begin
                        // Leaving PAUSE counts on the same edge, so a pause of
                        // N edges delays the next tick by exactly N cycles.
                        w_state_nxt = ST_RUN;
                        if (w_cnt_zero) begin
                            w_tick_nxt       = 1'b1;
                            w_tick_count_nxt = r_tick_count + 8'd1;
                            w_active_nxt     = w_pend_nxt;
                            if (r_one_shot) begin
                                w_state_nxt = ST_IDLE;
                                w_cnt_clr   = 1'b1;
                            end else begin
                                w_cnt_load = 1'b1;
                            end
                        end else begin
                            w_cnt_en = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_active     <= ONE;
            r_pending    <= ONE;
            r_one_shot   <= 1'b0;
            r_tick       <= 1'b0;
            r_tick_count <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_active     <= w_active_nxt;
            r_pending    <= w_pend_nxt;
            r_one_shot   <= w_one_shot_nxt;
            r_tick       <= w_tick_nxt;
            r_tick_count <= w_tick_count_nxt;
        end
    end

    rate_down_counter #(.WIDTH(WIDTH)) u_counter (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_clr      (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_en       (w_cnt_en),
        .i_load_val (w_load_val),
        .o_zero     (w_cnt_zero)
    );

    assign tick       = r_tick;
    assign state      = r_state;
    assign tick_count = r_tick_count;

endmodule
